// File: rtl/mem_responder.sv
// mem_responder: slow backing-store model answering cache fill/writeback requests
// over a four-phase req/ack handshake with a fixed number of wait states.
module mem_responder #(
    parameter int d_width     = 8,
    parameter int a_width     = 8,
    parameter int depth       = 16,
    parameter int wait_cycles = 3
) (
    input  logic               clk_i,
    input  logic               clr_i,
    input  logic               req_i,
    input  logic               rw_i,
    input  logic [a_width-1:0] addr_i,
    input  logic [d_width-1:0] data_in_i,
    output logic [d_width-1:0] data_out_o,
    output logic               ack_o,
    output logic               busy_o,
    output logic               err_o,
    output logic [1:0]         state_o,
    input  logic [3:0]         mon_addr_i,
    output logic [d_width-1:0] mon_data_o
);
    localparam int ix_w = $clog2(depth);
    localparam logic [a_width:0] depth_c = (a_width+1)'(depth);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2, BAD = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [a_width-1:0] addr_q, addr_d;
    logic               rw_q, rw_d;
    logic [d_width-1:0] wdata_q, wdata_d;
    logic [d_width-1:0] dout_q, dout_d;
    logic               err_q, err_d;
    logic               we;
    logic               in_range;
    logic [ix_w-1:0]    idx;
    logic [d_width-1:0] mem_q [depth];

    assign in_range   = {1'b0, addr_q} < depth_c;
    assign idx        = addr_q[ix_w-1:0];
    assign data_out_o = dout_q;
    assign err_o      = err_q;
    assign ack_o      = state_q == RESP;
    assign busy_o     = state_q == WAIT || state_q == RESP;
    assign state_o    = state_q;
    assign mon_data_o = mem_q[mon_addr_i];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        err_d   = err_q;
        we      = 1'b0;
        case (state_q)
            IDLE: if (req_i) begin
                state_d = WAIT;
                cnt_d   = wait_cycles[3:0];
                addr_d  = addr_i;
                rw_d    = rw_i;
                wdata_d = data_in_i;
            end
            WAIT: if (cnt_q != 4'd0) begin
                cnt_d = cnt_q - 4'd1;
            end else begin
                state_d = RESP;
                err_d   = ~in_range;
                we      = in_range & rw_q;
                dout_d  = !in_range ? '0 : (!rw_q ? mem_q[idx] : dout_q);
            end
            RESP: if (!req_i) begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                dout_d  = '0;
                err_d   = 1'b0;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Reset also wipes the store so every run starts from all-zero memory.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            dout_q  <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < depth; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            err_q   <= err_d;
            if (we) mem_q[idx] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed transactions with a queue of expected responses popped
// by an independent monitor on every rising ack.
module tb_mem_responder;
    logic       clk_i = 1'b0;
    logic       clr_i = 1'b1;
    logic       req_i = 1'b0;
    logic       req_f = 1'b0;
    logic       rw_i = 1'b0;
    logic [7:0] addr_i = '0;
    logic [7:0] data_in_i = '0;
    logic [3:0] mon_addr_i = '0;
    logic [7:0] data_out_o, mon_data_o, data_out_f, mon_data_f;
    logic       ack_o, busy_o, err_o, ack_f, busy_f, err_f;
    logic [1:0] state_o, state_f;

    typedef struct {logic [7:0] d; logic e;} exp_t;
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_mem [16];
    logic [7:0] model_dout = '0;
    logic       ack_prev = 1'b0;

    mem_responder #(.wait_cycles(3)) dut (
        .clk_i(clk_i), .clr_i(clr_i), .req_i(req_i), .rw_i(rw_i), .addr_i(addr_i),
        .data_in_i(data_in_i), .data_out_o(data_out_o), .ack_o(ack_o), .busy_o(busy_o),
        .err_o(err_o), .state_o(state_o), .mon_addr_i(mon_addr_i), .mon_data_o(mon_data_o)
    );

    mem_responder #(.wait_cycles(0)) u_fast (
        .clk_i(clk_i), .clr_i(clr_i), .req_i(req_f), .rw_i(rw_i), .addr_i(addr_i),
        .data_in_i(data_in_i), .data_out_o(data_out_f), .ack_o(ack_f), .busy_o(busy_f),
        .err_o(err_f), .state_o(state_f), .mon_addr_i(mon_addr_i), .mon_data_o(mon_data_f)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        model_dout = '0;
    endtask

    task automatic check_mem(input string name);
        for (int i = 0; i < 16; i++) begin
            mon_addr_i = 4'(i);
            #1;
            chk(name, {24'b0, mon_data_o}, {24'b0, model_mem[i]});
        end
    endtask

    task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                       input int hold, input bit toggle);
        exp_t e;
        int   n;
        if (a < 8'd16) begin
            if (w) model_mem[a[3:0]] = d;
            else   model_dout = model_mem[a[3:0]];
            e.e = 1'b0;
        end else begin
            model_dout = '0;
            e.e = 1'b1;
        end
        e.d = model_dout;
        sb.push_back(e);
        req_i = 1'b1; rw_i = w; addr_i = a; data_in_i = d;
        tick();
        chk("wait_state", {30'b0, state_o}, 32'd1);
        if (toggle) begin
            addr_i = ~a; data_in_i = ~d; rw_i = ~w;
        end
        n = 0;
        do begin
            if (!ack_o) chk("busy_wait", {31'b0, busy_o}, 32'd1);
            tick();
            n++;
        end while (!ack_o && n < 20);
        chk("latency", n, 32'd4);
        chk("busy_resp", {31'b0, busy_o}, 32'd1);
        repeat (hold) begin
            tick();
            chk("hold_ack", {31'b0, ack_o}, 32'd1);
            chk("hold_state", {30'b0, state_o}, 32'd2);
        end
        req_i = 1'b0;
        tick();
        chk("drop_ack", {31'b0, ack_o}, 32'd0);
        chk("drop_state", {30'b0, state_o}, 32'd0);
        chk("drop_err", {31'b0, err_o}, 32'd0);
        chk("drop_busy", {31'b0, busy_o}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_ack"}, {31'b0, ack_o}, 32'd0);
        chk({name, "_busy"}, {31'b0, busy_o}, 32'd0);
        chk({name, "_err"}, {31'b0, err_o}, 32'd0);
        chk({name, "_dout"}, {24'b0, data_out_o}, 32'd0);
        chk({name, "_state"}, {30'b0, state_o}, 32'd0);
    endtask

    always @(posedge clk_i) begin
        #1;
        if (ack_o && !ack_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_data", {24'b0, data_out_o}, {24'b0, e.d});
                chk("resp_err", {31'b0, err_o}, {31'b0, e.e});
            end
        end
        ack_prev = ack_o;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        tick();
        clr_i = 1'b0;
        tick();
        check_reset_outputs("reset0");
        txn(1'b1, 8'h01, 8'h11, 0, 0);
        txn(1'b1, 8'h03, 8'h33, 0, 0);
        txn(1'b0, 8'h03, 8'h00, 0, 0);
        // Reset while a transaction is mid-flight.
        req_i = 1'b1; rw_i = 1'b0; addr_i = 8'h01;
        tick();
        tick();
        clr_i = 1'b1; req_i = 1'b0;
        tick();
        clr_i = 1'b0;
        model_reset();
        check_reset_outputs("reset1");
        check_mem("reset_mem");
        txn(1'b1, 8'h05, 8'hA5, 0, 0);
        mon_addr_i = 4'd5;
        #1;
        chk("write_mon", {24'b0, mon_data_o}, 32'hA5);
        txn(1'b0, 8'h05, 8'h00, 0, 1);
        check_mem("read_mem");
        txn(1'b1, 8'h20, 8'h3C, 0, 0);
        check_mem("range_mem");
        req_i = 1'b1; rw_i = 1'b1; addr_i = 8'h02; data_in_i = 8'h77;
        tick();
        tick();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0; req_i = 1'b0;
        model_reset();
        chk("midop_state", {30'b0, state_o}, 32'd0);
        repeat (6) begin
            tick();
            chk("midop_ack", {31'b0, ack_o}, 32'd0);
        end
        mon_addr_i = 4'd2;
        #1;
        chk("midop_mem2", {24'b0, mon_data_o}, 32'd0);
        txn(1'b1, 8'h07, 8'h5A, 10, 0);
        txn(1'b0, 8'h07, 8'h00, 10, 0);
        check_mem("hold_mem");
        rw_i = 1'b0; addr_i = 8'h03; req_f = 1'b1;
        tick();
        chk("fast_wait_ack", {31'b0, ack_f}, 32'd0);
        chk("fast_wait_busy", {31'b0, busy_f}, 32'd1);
        tick();
        chk("fast_ack", {31'b0, ack_f}, 32'd1);
        chk("fast_err", {31'b0, err_f}, 32'd0);
        chk("fast_dout", {24'b0, data_out_f}, 32'd0);
        req_f = 1'b0;
        tick();
        chk("fast_drop", {31'b0, ack_f}, 32'd0);
        chk("fast_state", {30'b0, state_f}, 32'd0);
        chk("fast_mon", {24'b0, mon_data_f}, 32'd0);
        tick();
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
